zf_vec_apply_4x4_4x1: RTL
=========================

# zf_vec_apply_4x4_4x1

Downstream stage of the 4x4 x 4x4 matrix multiplier in the 2x2 MIMO ZF detector.
- Takes the 4x4 real-valued ZF weight matrix W (the multiplier's 256-bit result) and a 4x1 real-valued received vector y.
- Computes x = W·y row-serially on four parallel 16-bit multipliers, one row per cycle.
- Uses the same enable / accept_in / accept_out / ready_out handshake as the rest of the pipeline.
- A weight-hold option lets successive received vectors reuse the last captured W without reloading it.

## Interface
Parameters:
- FRAC, 12, fractional bits of the signed 16-bit fixed-point format (Q3.12).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  start request; sampled only in IDLE.
- hold_w  in  1  when 1 with enable, keep the stored W and capture only y.
- accept_in  in  1  downstream has taken x; sampled only in READY.
- W  in  256  weight matrix, row-major; element (r,c) at W[255-64r-16c -: 16].
- y  in  64  received vector; element c at y[63-16c -: 16].
- accept_out  out  1  high in IDLE: block can take new inputs.
- ready_out  out  1  high in READY: x and sat are valid.
- x  out  64  result; element r at x[63-16r -: 16].
- sat  out  1  set if any element of the current result saturated.

## Operation
- Internal registers:
  - W_reg: 256 bits.
  - y_reg: 64 bits.
  - row counter: 2 bits.
  - x: 4x16 bits.
  - sat.
- FSM states: IDLE, CALC, READY.
- IDLE -> CALC when enable=1. At that edge:
  - y_reg <= y.
  - W_reg <= W, unless hold_w=1.
  - row <= 0; sat <= 0.
  - x is held (not cleared).
- CALC: each cycle computes row r = row and, at the next edge:
  - Writes x[r] and ORs that row's saturation into sat.
  - row increments.
  - When row=3, state goes to READY instead.
- READY -> IDLE when accept_in=1; otherwise READY holds.
- enable is ignored outside IDLE; accept_in is ignored outside READY.
- Arithmetic for row r:
  - p_c = W_reg(r,c) * y_reg(c): signed 16x16 -> 32-bit product.
  - q_c = p_c >>> FRAC: arithmetic shift (floor), kept as 20-bit signed.
  - s = q_0+q_1+q_2+q_3 in a 22-bit signed accumulator; no intermediate overflow is possible.
  - x[r] = s clamped to [-32768, 32767]. Row saturation = (s was clamped).
- x and sat hold their values from READY through IDLE until the next CALC writes them.
- Reset, at any time including mid-CALC:
  - state = IDLE; row, W_reg, y_reg, x and sat are all cleared to 0.
  - An in-flight operation is abandoned; no partial result is flagged.
- hold_w=1 on the first operation after reset uses W_reg=0, so x=0.

## Timing
- Reset values: accept_out=1, ready_out=0, x=0, sat=0.
- accept_out and ready_out decode the state register combinationally; they are glitch-free with respect to state.
- Let E0 be the edge that samples enable in IDLE:
  - Rows 0..3 are written at E1..E4.
  - ready_out is high from E4 onward, i.e. 4 cycles after enable is sampled.
- accept_out goes low at E0 and returns high at the edge that samples accept_in=1 in READY.
- Minimum initiation interval is 6 cycles: 4 CALC cycles, 1 READY cycle (accept_in already high), 1 IDLE cycle.
- W and y need only be stable in the cycle enable is sampled; they are don't-care afterwards.
- enable and accept_in both high in READY: only the READY->IDLE transition occurs; the enable is not registered.

## Test plan
- **Identity:** W = diag(0x1000), y = (0x1000, 0x2000, 0xF000, 0x0123), enable one cycle -> ready_out rises 4 cycles later; x = y; sat=0; accept_out low throughout the operation.
- **Positive saturation and floor truncation:**
  - Row 0 all 0x7FFF, y all 0x7FFF -> x[0]=0x7FFF, sat=1.
  - Row 1 = (0xFFFF,0,0,0) with y0=0x0800 -> x[1]=0xFFFF (floor of -0.5 LSB).
  - Row 2 = (0x0001,0,0,0) -> x[2]=0x0000.
- **Negative saturation:** row 3 all 0x8000, y all 0x7FFF -> x[3]=0x8000, sat=1.
- **Weight hold:** load W = diag(0x2000) with hold_w=0, y=(0x0100,..). Then change the W input to all zeros and apply y' = (0x0400,0x0400,0x0400,0x0400) with hold_w=1 -> x = (0x0800,0x0800,0x0800,0x0800), sat=0.
- **Handshake stalls:** keep accept_in=0 for 10 cycles in READY -> ready_out stays high and x is stable; enable pulses during READY are ignored. Assert accept_in -> accept_out high on the next cycle; the following enable starts a new operation.
- **Reset mid-CALC:** assert reset_n=0 asynchronously after E2 -> accept_out=1, ready_out=0, x=0, sat=0 immediately. The next normal operation after release gives correct results.

Source files
------------

// File: rtl/zf_vec_apply_4x4_4x1_if.sv
// Handshake and data bus between the ZF weight source / vector source and the W*y stage.
interface zf_vec_apply_4x4_4x1_if;
  logic         enable;
  logic         hold_w;
  logic         accept_in;
  logic [255:0] W;
  logic [63:0]  y;
  logic         accept_out;
  logic         ready_out;
  logic [63:0]  x;
  logic         sat;

  modport master (
    output enable, hold_w, accept_in, W, y,
    input  accept_out, ready_out, x, sat
  );

  modport slave (
    input  enable, hold_w, accept_in, W, y,
    output accept_out, ready_out, x, sat
  );
endinterface

// File: rtl/zf_vec_apply_4x4_4x1.sv
// Applies a captured 4x4 Q3.12 ZF weight matrix to a 4x1 received vector, one row per cycle.
module zf_vec_apply_4x4_4x1 #(
  parameter int unsigned FRAC = 12
) (
  input logic                     clk,
  input logic                     reset_n,
  zf_vec_apply_4x4_4x1_if.slave   bus
);

  localparam int unsigned ELEM_W = 16;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned Q_W    = 20;
  localparam int unsigned ACC_W  = 22;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_start;
  logic          w_row_we;

  logic [255:0]  r_w;
  logic [63:0]   r_y;
  logic [1:0]    r_row;
  logic [63:0]   r_x;
  logic          r_sat;

  logic signed [ELEM_W-1:0] w_wel [4];
  logic signed [ELEM_W-1:0] w_yel [4];
  logic signed [PROD_W-1:0] w_p   [4];
  logic signed [Q_W-1:0]    w_q   [4];
  logic signed [ACC_W-1:0]  w_s;
  logic [ELEM_W-1:0]        w_row_val;
  logic                     w_row_sat;
  logic [63:0]              w_x_nxt;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_row_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          w_state_nxt = S_CALC;
          w_start     = 1'b1;
        end
      end
      S_CALC: begin
        w_row_we = 1'b1;
        if (r_row == 2'd3) begin
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (bus.accept_in) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Select the current row of W and unpack y into signed elements
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_yel[c] = r_y[63-16*c -: 16];
      w_wel[c] = '0;
      case (r_row)
        2'd0:    w_wel[c] = r_w[255-16*c -: 16];
        2'd1:    w_wel[c] = r_w[191-16*c -: 16];
        2'd2:    w_wel[c] = r_w[127-16*c -: 16];
        default: w_wel[c] = r_w[63-16*c -: 16];
      endcase
    end
  end

  // Four parallel products, floor-shifted to Q3.12 and summed; 22 bits cannot overflow
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_p[c] = PROD_W'(w_wel[c]) * PROD_W'(w_yel[c]);
      w_q[c] = Q_W'(w_p[c] >>> FRAC);
    end
    w_s = ACC_W'(w_q[0]) + ACC_W'(w_q[1]) + ACC_W'(w_q[2]) + ACC_W'(w_q[3]);
  end

  // Clamp the row sum into 16 bits and flag saturation
  always_comb begin
    w_row_val = w_s[ELEM_W-1:0];
    w_row_sat = 1'b0;
    if (w_s > 22'sd32767) begin
      w_row_val = 16'h7FFF;
      w_row_sat = 1'b1;
    end else if (w_s < -22'sd32768) begin
      w_row_val = 16'h8000;
      w_row_sat = 1'b1;
    end
  end

  // Merge the new row into the result vector
  always_comb begin
    w_x_nxt = r_x;
    case (r_row)
      2'd0:    w_x_nxt[63:48] = w_row_val;
      2'd1:    w_x_nxt[47:32] = w_row_val;
      2'd2:    w_x_nxt[31:16] = w_row_val;
      default: w_x_nxt[15:0]  = w_row_val;
    endcase
  end

  // Operand capture, row counter and result registers; x is held across IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_w   <= '0;
      r_y   <= '0;
      r_row <= '0;
      r_x   <= '0;
      r_sat <= 1'b0;
    end else if (w_start) begin
      r_y   <= bus.y;
      if (!bus.hold_w) begin
        r_w <= bus.W;
      end
      r_row <= '0;
      r_sat <= 1'b0;
    end else if (w_row_we) begin
      r_x   <= w_x_nxt;
      r_sat <= r_sat | w_row_sat;
      r_row <= r_row + 2'd1;
    end
  end

  assign bus.accept_out = (r_state == S_IDLE);
  assign bus.ready_out  = (r_state == S_READY);
  assign bus.x          = r_x;
  assign bus.sat        = r_sat;

endmodule
